tag_return_pipe: RTL

//  Parametrised bubble-collapsing delay pipeline for packet completion tags. Each accepted
//  end-of-packet event becomes a tag {seq, channel}, returned on tagstream after at least

---
 rtl/tag_pipe_pkg.sv | 15 +
 rtl/tag_pipe_stage.sv | 31 +++
 rtl/tag_return_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tag_pipe_pkg.sv
// Shared defaults and tag layout for the tag return pipeline.
package tag_pipe_pkg;

  localparam int DEF_DEPTH    = 7;
  localparam int DEF_CHANNELS = 64;
  localparam int DEF_SEQ_W    = 2;
  localparam int CH_W         = $clog2(DEF_CHANNELS);
  localparam int TAG_W        = DEF_SEQ_W + CH_W;

  typedef struct packed {
    logic [DEF_SEQ_W-1:0] seq;
    logic [CH_W-1:0]      channel;
  } tag_t;

endpackage

// File: rtl/tag_pipe_stage.sv
// One pipeline slot: a valid bit plus tag payload, loaded from the slot
// behind it when the advance chain allows, cleared by flush.
module tag_pipe_stage
  import tag_pipe_pkg::*;
#(
  parameter int W = TAG_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= in_valid;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/tag_return_pipe.sv
// Bubble-collapsing delay pipe returning {seq, channel} completion tags.
// Optional statistics counters are built when TAG_PIPE_STATS_EN is defined.
module tag_return_pipe
  import tag_pipe_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEQ_W    = DEF_SEQ_W,
  localparam int P_CH_W  = $clog2(CHANNELS),
  localparam int P_TAG_W = SEQ_W + P_CH_W,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               evt_valid,
  input  logic [P_CH_W-1:0]  evt_channel,
  output logic               evt_ready,
  output logic [P_TAG_W-1:0] tagstream_data,
  output logic               tagstream_valid,
  input  logic               tagstream_ready,
  output logic [OCC_W-1:0]   occupancy,
  output logic               overflow,
  output logic               chan_err,
  input  logic               clr_err,
  output logic [31:0]        emit_count,
  output logic [31:0]        drop_count
);

  logic [DEPTH-1:0]   v;
  logic [DEPTH-1:0]   adv;
  logic [DEPTH-1:0]   nxt_v;
  logic [P_TAG_W-1:0] d [DEPTH];
  logic [SEQ_W-1:0]   seq;
  logic               chan_ok;
  logic               accept;
  logic               ovf_evt;
  logic               chan_evt;
  logic [OCC_W-1:0]   occ_next;

  assign chan_ok   = 32'(evt_channel) < 32'(CHANNELS);
  assign evt_ready = reset_n & adv[0] & !flush;
  assign accept    = evt_valid & evt_ready & chan_ok;
  assign chan_evt  = evt_valid & !flush & !chan_ok;
  assign ovf_evt   = evt_valid & !flush & chan_ok & !adv[0];

  assign tagstream_valid = v[DEPTH-1];
  assign tagstream_data  = d[DEPTH-1];

  // A stage may advance unless it and every stage ahead are full with the head stalled.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic               in_v;
    logic [P_TAG_W-1:0] in_d;

    assign adv[i] = tagstream_ready | ~(&v[DEPTH-1:i]);

    if (i == 0) begin : g_first
      assign in_v = accept;
      assign in_d = {seq, evt_channel};
    end else begin : g_rest
      assign in_v = v[i-1];
      assign in_d = d[i-1];
    end

    assign nxt_v[i] = !flush & (adv[i] ? in_v : v[i]);

    tag_pipe_stage #(.W(P_TAG_W)) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .flush    (flush),
      .load     (adv[i]),
      .in_valid (in_v),
      .in_data  (in_d),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(nxt_v[i]);
    end
  end

  // Seq only moves on accepted tags so dropped events never leave a gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq       <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      chan_err  <= 1'b0;
    end else begin
      if (accept) seq <= seq + 1'b1;
      occupancy <= occ_next;
      overflow  <= (overflow & !clr_err) | ovf_evt;
      chan_err  <= (chan_err & !clr_err) | chan_evt;
    end
  end

`ifdef TAG_PIPE_STATS_EN
  logic emit;
  logic drop;

  assign emit = v[DEPTH-1] & tagstream_ready & !flush;
  assign drop = ovf_evt | chan_evt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      emit_count <= '0;
      drop_count <= '0;
    end else begin
      if (emit && emit_count != '1) emit_count <= emit_count + 32'd1;
      if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
    end
  end
`else
  assign emit_count = '0;
  assign drop_count = '0;
`endif

endmodule
